ps2_keypad: RTL and testbench

- Receives a PS/2 keyboard stream and converts Set-2 scan codes into the held key levels and press pulses consumed by the game controller (enter, pause, up, down, left, right).
- Sits between the board PS/2 pins and the controller's key inputs.
- Runs entirely in the system clk domain and oversamples the PS/2 lines.

---
 rtl/game_pkg.sv | 24 ++
 rtl/ps2_rx.sv | 102 ++++++++++
 rtl/ps2_keypad.sv | 130 +++++++++++++
 tb/tb_ps2_keypad.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - Scan-code constants and PS/2 frame state for the keypad front end
package game_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchronizer, falling-edge sampler, frame FSM and timeout
module ps2_rx
  import game_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_fall;
  logic                   w_data;

  rx_state_t r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [CW-1:0] r_tmo_cnt;

  // Synchronize both pins; idle PS/2 lines are high, so reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_data = r_data_sync[SYNC_STAGES-1];

  // Frame FSM: one bit per falling edge, timeout aborts a stalled partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_parity     <= 1'b0;
      r_tmo_cnt    <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;

      if (r_state == IDLE || w_fall) r_tmo_cnt <= '0;
      else                           r_tmo_cnt <= r_tmo_cnt + 1'b1;

      if (r_state != IDLE && !w_fall && r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        o_frame_err <= 1'b1;
        r_state     <= IDLE;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state   <= PARITY;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          STOP: begin
            if (w_data && (^{r_shift, r_parity})) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// rtl/ps2_keypad.sv - Set-2 scan-code decoder to game key levels/pulses; PS2_WASD_ALIAS_EN adds WASD aliases
module ps2_keypad
  import game_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic enter,
  output logic pause,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic enter_press,
  output logic pause_press,
  output logic frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  logic r_ext, r_brk;
  logic r_enter, r_pause;
  logic r_up, r_down, r_left, r_right;
  logic r_enter_press, r_pause_press;
`ifdef PS2_WASD_ALIAS_EN
  logic r_up_wasd, r_down_wasd, r_left_wasd, r_right_wasd;
`endif

  ps2_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // Decode prefixes and codes into held levels; presses fire only on a low-to-high level change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_enter       <= 1'b0;
      r_pause       <= 1'b0;
      r_up          <= 1'b0;
      r_down        <= 1'b0;
      r_left        <= 1'b0;
      r_right       <= 1'b0;
      r_enter_press <= 1'b0;
      r_pause_press <= 1'b0;
`ifdef PS2_WASD_ALIAS_EN
      r_up_wasd     <= 1'b0;
      r_down_wasd   <= 1'b0;
      r_left_wasd   <= 1'b0;
      r_right_wasd  <= 1'b0;
`endif
    end else begin
      r_enter_press <= 1'b0;
      r_pause_press <= 1'b0;
      if (w_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_ext) begin
            case (w_byte)
              SC_ENTER: begin
                r_enter       <= !r_brk;
                r_enter_press <= !r_brk && !r_enter;
              end
              SC_P: begin
                r_pause       <= !r_brk;
                r_pause_press <= !r_brk && !r_pause;
              end
`ifdef PS2_WASD_ALIAS_EN
              SC_W:    r_up_wasd    <= !r_brk;
              SC_S:    r_down_wasd  <= !r_brk;
              SC_A:    r_left_wasd  <= !r_brk;
              SC_D:    r_right_wasd <= !r_brk;
`endif
              default: ;
            endcase
          end else begin
            case (w_byte)
              SC_UP:    r_up    <= !r_brk;
              SC_DOWN:  r_down  <= !r_brk;
              SC_LEFT:  r_left  <= !r_brk;
              SC_RIGHT: r_right <= !r_brk;
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign enter       = r_enter;
  assign pause       = r_pause;
  assign enter_press = r_enter_press;
  assign pause_press = r_pause_press;
  assign frame_err   = w_frame_err;
`ifdef PS2_WASD_ALIAS_EN
  assign up    = r_up    | r_up_wasd;
  assign down  = r_down  | r_down_wasd;
  assign left  = r_left  | r_left_wasd;
  assign right = r_right | r_right_wasd;
`else
  assign up    = r_up;
  assign down  = r_down;
  assign left  = r_left;
  assign right = r_right;
`endif

endmodule

// File: tb/tb_ps2_keypad.sv
// tb/tb_ps2_keypad.sv - Directed self-checking bench for ps2_keypad
`timescale 1ns/1ps
module tb_ps2_keypad;

  localparam int TMO  = 400;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic enter, pause, up, down, left, right;
  logic enter_press, pause_press, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int c_enter_press = 0;
  int c_pause_press = 0;
  int c_err = 0;

  ps2_keypad #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .enter       (enter),
    .pause       (pause),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .enter_press (enter_press),
    .pause_press (pause_press),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (enter_press) c_enter_press = c_enter_press + 1;
      if (pause_press) c_pause_press = c_pause_press + 1;
      if (frame_err)   c_err = c_err + 1;
    end
  end

  task automatic ps2_bit(input logic d);
    @(negedge clk);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    repeat (10) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(b, ~^b, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({enter, pause, up, down, left, right, enter_press, pause_press, frame_err} !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_outputs actual=%b expected=0",
               {enter, pause, up, down, left, right, enter_press, pause_press, frame_err});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_enter;
    int p0;
    p0 = c_enter_press;
    send(8'h5A);
    check("enter_make_level", enter, 1);
    check("enter_make_pulse_cycles", c_enter_press - p0, 1);
    send(8'hF0);
    send(8'h5A);
    check("enter_break_level", enter, 0);
    check("enter_break_no_pulse", c_enter_press - p0, 1);
  endtask

  task automatic test_ext;
    int p0;
    p0 = c_enter_press;
    send(8'hE0);
    send(8'h75);
    check("ext_up_make", up, 1);
    send(8'h5A);
    check("ext_up_with_enter", {up, enter}, 2'b11);
    check("ext_enter_pulse", c_enter_press - p0, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_up_break", {up, enter}, 2'b01);
    send(8'hF0);
    send(8'h5A);
    check("ext_enter_release", enter, 0);
  endtask

  task automatic test_typematic;
    int p0;
    p0 = c_pause_press;
    for (int i = 0; i < 3; i++) begin
      send(8'h4D);
      if (pause !== 1'b1) begin
        $display("FAIL typematic_level_%0d actual=%b expected=1", i, pause);
        n_errors++;
      end
      n_checks++;
    end
    check("typematic_single_pulse", c_pause_press - p0, 1);
    send(8'hF0);
    send(8'h4D);
    check("pause_release", pause, 0);
  endtask

  task automatic test_numpad;
    send(8'h75);
    send(8'h6B);
    check("numpad_no_arrow", {up, down, left, right}, 4'b0000);
    send(8'hE0);
    send(8'h6B);
    send(8'hE0);
    send(8'h74);
    check("left_right_both", {left, right}, 2'b11);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("left_right_released", {left, right}, 2'b00);
  endtask

  task automatic test_parity;
    int e0;
    e0 = c_err;
    send_raw(8'h5A, 1'b0, 1'b1);
    check("parity_err_pulse", c_err - e0, 1);
    check("parity_enter_low", enter, 0);
    send(8'h5A);
    check("parity_recover_enter", enter, 1);
    send(8'hF0);
    send(8'h5A);
  endtask

  task automatic test_bad_stop;
    int e0;
    e0 = c_err;
    send_raw(8'h4D, 1'b0, 1'b0);
    check("stop_err_pulse", c_err - e0, 1);
    check("stop_pause_low", pause, 0);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = c_err;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (TMO + 1) @(negedge clk);
    check("timeout_err_once", c_err - e0, 1);
    send(8'h4D);
    check("timeout_recover_pause", pause, 1);
    check("timeout_no_extra_err", c_err - e0, 1);
    send(8'hF0);
    send(8'h4D);
  endtask

  task automatic test_reset_ext;
    int p0;
    send(8'h5A);
    send(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({enter, pause, up, down, left, right, enter_press, pause_press, frame_err} !== 9'd0) begin
      n_errors++;
      $display("FAIL post_reset_outputs actual=%b expected=0",
               {enter, pause, up, down, left, right, enter_press, pause_press, frame_err});
    end
    p0 = c_enter_press;
    send(8'h75);
    check("reset_cleared_ext", up, 0);
    check("reset_no_pulse", c_enter_press - p0, 0);
`ifdef PS2_WASD_ALIAS_EN
    send(8'h1D);
    check("wasd_w_up", up, 1);
    send(8'hE0);
    send(8'h75);
    send(8'hF0);
    send(8'h1D);
    check("wasd_release_arrow_held", up, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("wasd_all_released", up, 0);
`else
    send(8'h1D);
    check("wasd_unmapped", up, 0);
`endif
  endtask

  initial begin
    test_reset;
    test_enter;
    test_ext;
    test_typematic;
    test_numpad;
    test_parity;
    test_bad_stop;
    test_timeout;
    test_reset_ext;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
